// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: branch opcodes, comparator forwarding codes and
// the branch hazard FSM state encoding.
package pipeline_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_RESOLVE = 2'd2
  } bh_state_t;

  function automatic logic is_branch(input logic valid, input logic [5:0] opcode);
    return valid && (opcode == OP_BEQ || opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/branch_fwd_unit.sv
// Hazard detection and comparator-operand forwarding for one ID-stage
// source register.
module branch_fwd_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] opnd,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_rd,
  input  logic       mem_regwrite,
  input  logic       mem_memread,
  input  logic [4:0] mem_rd,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_rd,
  output logic       ex_hit,
  output logic       mem_hit,
  output logic [1:0] fwd
);

  assign ex_hit  = ex_regwrite  && (ex_rd  != 5'd0) && (ex_rd  == opnd);
  assign mem_hit = mem_regwrite && (mem_rd != 5'd0) && (mem_rd == opnd);

  // A load still in EX/MEM has no data yet, so only ALU results forward from there.
  always_comb begin
    fwd = FWD_RF;
    if (mem_hit && !mem_memread)
      fwd = FWD_MEM;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == opnd))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch resolution control: stalls for unresolved producers,
// selects comparator forwarding, and counts resolved / taken branches.
module branch_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             salto,
  input  logic             flush_in,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             take_branch,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  bh_state_t  state;
  logic [1:0] cnt;
  logic [1:0] need;
  logic       br, active, resolve;
  logic       ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic [1:0] fwd_rs, fwd_rt;

  branch_fwd_unit u_fwd_rs (
    .opnd(id_rs), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .ex_hit(ex_hit_rs), .mem_hit(mem_hit_rs), .fwd(fwd_rs)
  );

  branch_fwd_unit u_fwd_rt (
    .opnd(id_rt), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .ex_hit(ex_hit_rt), .mem_hit(mem_hit_rt), .fwd(fwd_rt)
  );

  // Cycles the comparator must wait before its operands are forwardable.
  always_comb begin
    need = 2'd0;
    if (ex_hit_rs || ex_hit_rt)
      need = ex_memread ? 2'd2 : 2'd1;
    else if ((mem_hit_rs || mem_hit_rt) && mem_memread)
      need = 2'd1;
  end

  assign br      = is_branch(id_valid, id_opcode);
  assign active  = reset_n && !flush_in;
  assign stall   = active && ((state == ST_IDLE && br && need != 2'd0) || state == ST_STALL);
  assign resolve = active && ((state == ST_IDLE && br && need == 2'd0) || state == ST_RESOLVE);

  assign take_branch = resolve && salto;
  assign fwd_a       = resolve ? fwd_rs : FWD_RF;
  assign fwd_b       = resolve ? fwd_rt : FWD_RF;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (flush_in) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else begin
      if (resolve) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
        if (salto)
          taken_cnt <= taken_cnt + CNT_W'(1);
      end
      unique case (state)
        ST_IDLE: begin
          if (br && need != 2'd0) begin
            cnt   <= need - 2'd1;
            state <= (need == 2'd1) ? ST_RESOLVE : ST_STALL;
          end
        end
        ST_STALL: begin
          if (cnt <= 2'd1) begin
            cnt   <= 2'd0;
            state <= ST_RESOLVE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ST_RESOLVE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Randomized and directed check of branch_hazard_ctrl against a
// cycle-count model of branch stalling, forwarding and statistics.
module tb_branch_hazard_ctrl;

  localparam int CW = 4;
  localparam int MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          id_valid;
  logic [5:0]    id_opcode;
  logic [4:0]    id_rs, id_rt;
  logic          ex_regwrite, ex_memread;
  logic [4:0]    ex_rd;
  logic          mem_regwrite, mem_memread;
  logic [4:0]    mem_rd;
  logic          wb_regwrite;
  logic [4:0]    wb_rd;
  logic          salto, flush_in;
  logic          stall, take_branch;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] branch_cnt, taken_cnt;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .salto(salto), .flush_in(flush_in),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .take_branch(take_branch),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Model: a pending branch waits m_rem more stall cycles, then resolves.
  bit m_busy = 0;
  int m_rem  = 0;
  int m_bcnt = 0;
  int m_tcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_br();
    return id_valid && (id_opcode == 6'd4 || id_opcode == 6'd5);
  endfunction

  function automatic bit hit(input logic we, input logic [4:0] rd);
    return we && rd != 5'd0 && (rd == id_rs || rd == id_rt);
  endfunction

  function automatic int need_cycles();
    int n = 0;
    if (hit(ex_regwrite, ex_rd) && ex_memread) n = 2;
    if (hit(ex_regwrite, ex_rd) && !ex_memread && n < 1) n = 1;
    if (hit(mem_regwrite, mem_rd) && mem_memread && n < 1) n = 1;
    return n;
  endfunction

  function automatic int src(input logic [4:0] r);
    if (mem_regwrite && mem_rd != 5'd0 && !mem_memread && mem_rd == r) return 1;
    if (wb_regwrite && wb_rd != 5'd0 && wb_rd == r) return 2;
    return 0;
  endfunction

  // Compare all outputs against the model at the negedge, then advance the model.
  task automatic step();
    bit res = 0;
    int e_stall = 0, e_take = 0, e_fa = 0, e_fb = 0;
    @(negedge clk);
    if (reset_n && !flush_in) begin
      if (m_busy) begin
        if (m_rem > 0) e_stall = 1; else res = 1;
      end else if (is_br()) begin
        if (need_cycles() == 0) res = 1; else e_stall = 1;
      end
    end
    if (res) begin
      e_take = int'(salto);
      e_fa   = src(id_rs);
      e_fb   = src(id_rt);
    end
    chk("stall", int'(stall), e_stall);
    chk("take_branch", int'(take_branch), e_take);
    chk("fwd_a", int'(fwd_a), e_fa);
    chk("fwd_b", int'(fwd_b), e_fb);
    chk("branch_cnt", int'(branch_cnt), m_bcnt);
    chk("taken_cnt", int'(taken_cnt), m_tcnt);
    if (!reset_n) begin
      m_busy = 0; m_rem = 0; m_bcnt = 0; m_tcnt = 0;
    end else if (flush_in) begin
      m_busy = 0; m_rem = 0;
    end else if (res) begin
      m_busy = 0;
      m_bcnt = (m_bcnt + 1) % MOD;
      if (salto) m_tcnt = (m_tcnt + 1) % MOD;
    end else if (e_stall != 0) begin
      if (m_busy) m_rem--;
      else begin m_busy = 1; m_rem = need_cycles() - 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    reset_n = 1; id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_regwrite = 0; wb_rd = 0; salto = 0; flush_in = 0;
  endtask

  task automatic branch(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic s);
    id_valid = 1; id_opcode = op; id_rs = rs; id_rt = rt; salto = s;
  endtask

  initial begin
    clr();
    reset_n = 0;
    step(); step();
    clr(); #2;
    chk("rst_stall", int'(stall), 0);
    chk("rst_bcnt", int'(branch_cnt), 0);
    step();

    // BEQ with no producers resolves in the same cycle
    branch(6'd4, 5'd3, 5'd4, 1'b1); #2;
    chk("beq_nohaz_stall", int'(stall), 0);
    chk("beq_nohaz_take", int'(take_branch), 1);
    chk("beq_nohaz_fwd", int'({fwd_a, fwd_b}), 0);
    step();
    clr(); #2;
    chk("beq_nohaz_bcnt", int'(branch_cnt), 1);
    chk("beq_nohaz_tcnt", int'(taken_cnt), 1);
    step();

    // BNE after an ALU write to rs: one stall, then forward from EX/MEM
    branch(6'd5, 5'd5, 5'd6, 1'b1); ex_regwrite = 1; ex_rd = 5'd5; #2;
    chk("bne_alu_stall", int'(stall), 1);
    chk("bne_alu_take0", int'(take_branch), 0);
    step();
    ex_regwrite = 0; ex_rd = 0; mem_regwrite = 1; mem_rd = 5'd5; #2;
    chk("bne_alu_res_stall", int'(stall), 0);
    chk("bne_alu_fwd_a", int'(fwd_a), 1);
    chk("bne_alu_take", int'(take_branch), 1);
    step();
    clr(); step();

    // BEQ after a load to rt: two stalls, then forward from MEM/WB
    branch(6'd4, 5'd1, 5'd7, 1'b0); ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd7; #2;
    chk("beq_ld_stall1", int'(stall), 1);
    step();
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd7; #2;
    chk("beq_ld_stall2", int'(stall), 1);
    step();
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0; wb_regwrite = 1; wb_rd = 5'd7; #2;
    chk("beq_ld_res_stall", int'(stall), 0);
    chk("beq_ld_fwd_b", int'(fwd_b), 2);
    chk("beq_ld_take", int'(take_branch), 0);
    step();
    clr(); #2;
    chk("beq_ld_bcnt", int'(branch_cnt), 3);
    chk("beq_ld_tcnt", int'(taken_cnt), 2);
    step();

    // r0 never creates a hazard
    branch(6'd4, 5'd0, 5'd0, 1'b1); ex_regwrite = 1; ex_rd = 5'd0; #2;
    chk("r0_stall", int'(stall), 0);
    chk("r0_take", int'(take_branch), 1);
    step();

    // flush in STALL returns to IDLE without counting
    clr(); branch(6'd4, 5'd2, 5'd9, 1'b1); ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd2;
    step();
    clr(); flush_in = 1; #2;
    chk("flush_stall", int'(stall), 0);
    chk("flush_take", int'(take_branch), 0);
    step();
    clr(); branch(6'd5, 5'd8, 5'd9, 1'b1); #2;
    chk("flush_bcnt", int'(branch_cnt), 4);
    chk("post_flush_idle_take", int'(take_branch), 1);
    step();

    // flush coinciding with a resolve wins
    clr(); branch(6'd4, 5'd8, 5'd9, 1'b1); flush_in = 1; #2;
    chk("flush_res_take", int'(take_branch), 0);
    step();
    clr(); #2;
    chk("flush_res_bcnt", int'(branch_cnt), 5);
    step();

    // counter wraparound
    for (int i = 0; i < 2 * MOD && branch_cnt != CW'(MOD - 1); i++) begin
      clr(); branch(6'd4, 5'd1, 5'd2, 1'b0); step();
    end
    clr(); #2;
    chk("wrap_pre", int'(branch_cnt), MOD - 1);
    branch(6'd4, 5'd1, 5'd2, 1'b0); step();
    clr(); #2;
    chk("wrap_post", int'(branch_cnt), 0);
    step();

    // reset in the middle of a stall
    branch(6'd4, 5'd3, 5'd4, 1'b1); ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd3;
    step();
    reset_n = 0; #2;
    chk("rst_mid_stall", int'(stall), 0);
    chk("rst_mid_take", int'(take_branch), 0);
    chk("rst_mid_fwd", int'({fwd_a, fwd_b}), 0);
    step();
    clr(); branch(6'd4, 5'd3, 5'd4, 1'b1); #2;
    chk("rst_mid_bcnt", int'(branch_cnt), 0);
    chk("post_rst_take", int'(take_branch), 1);
    step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset_n      = ($urandom_range(0, 99) != 0);
      flush_in     = ($urandom_range(0, 15) == 0);
      id_valid     = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0:       id_opcode = 6'd4;
        1:       id_opcode = 6'd5;
        2:       id_opcode = 6'd4;
        default: id_opcode = 6'($urandom_range(0, 63));
      endcase
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_memread   = 1'($urandom_range(0, 1));
      ex_rd        = 5'($urandom_range(0, 7));
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_memread  = 1'($urandom_range(0, 1));
      mem_rd       = 5'($urandom_range(0, 7));
      wb_regwrite  = 1'($urandom_range(0, 1));
      wb_rd        = 5'($urandom_range(0, 7));
      salto        = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the statistics counters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-004 id_valid  in  1  instruction in IF/ID is valid.
REQ-005 id_opcode  in  6  opcode of instruction in ID.
REQ-006 id_rs  in  5  rs field in ID.
REQ-007 id_rt  in  5  rt field in ID.
REQ-008 ex_regwrite  in  1  ID/EX instruction writes a register.
REQ-009 ex_memread  in  1  ID/EX instruction is a load.
REQ-010 ex_rd  in  5  ID/EX destination register.
REQ-011 mem_regwrite  in  1  EX/MEM instruction writes a register.
REQ-012 mem_memread  in  1  EX/MEM instruction is a load.
REQ-013 mem_rd  in  5  EX/MEM destination register.
REQ-014 wb_regwrite  in  1  MEM/WB instruction writes a register.
REQ-015 wb_rd  in  5  MEM/WB destination register.
REQ-016 salto  in  1  branch-condition result from the ID-stage register comparator (BEQ equal / BNE not-equal).
REQ-017 flush_in  in  1  higher-priority pipeline flush (exception/jump).
REQ-018 stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-019 fwd_a  out  2  comparator operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-020 fwd_b  out  2  comparator operand B source, same encoding.
REQ-021 take_branch  out  1  select branch target for PC and flush IF/ID this cycle.
REQ-022 branch_cnt  out  CNT_W  branches resolved since reset.
REQ-023 taken_cnt  out  CNT_W  branches resolved taken since reset.

Function
REQ-024 Branch in ID SHALL mean id_valid=1 and id_opcode in {000100 BEQ, 000101 BNE}; other opcodes never stall or take.
REQ-025 Match on a stage SHALL mean its regwrite=1, its rd!=0, and rd equals id_rs or id_rt.
REQ-026 Required stall count N SHALL be max of: 2 if EX match with ex_memread; 1 if EX match without ex_memread; 1 if MEM match with mem_memread; else 0.
REQ-027 FSM states SHALL be IDLE, STALL, RESOLVE with internal 2-bit down-counter.
REQ-028 IDLE, branch, N=0: resolve same cycle (stall=0), stay IDLE.
REQ-029 IDLE, branch, N>0: stall=1 combinationally this cycle, load counter N-1; go RESOLVE if N=1, else STALL.
REQ-030 STALL: stall=1, counter decrements; go RESOLVE when counter reaches 0; no hazard recheck (ID held stable by stall).
REQ-031 RESOLVE: stall=0, resolve, return to IDLE next cycle.
REQ-032 Resolve cycle: take_branch=salto; branch_cnt+1; taken_cnt+1 if salto; counters wrap modulo 2^CNT_W.
REQ-033 fwd_a/fwd_b SHALL be computed combinationally in any resolve cycle: 01 if mem_regwrite, mem_rd!=0, not mem_memread, and mem_rd matches the operand; else 10 if wb_regwrite, wb_rd!=0, and wb_rd matches; else 00. EX/MEM wins over MEM/WB.
REQ-034 Outside a resolve cycle fwd_a=fwd_b=00 and take_branch=0.
REQ-035 flush_in=1 SHALL force stall=0, take_branch=0, no counter update, and next state IDLE from any state.
REQ-036 Simultaneous flush_in and resolve: flush wins, branch not counted.

Reset
REQ-037 reset_n=0 at a clock edge SHALL set state IDLE, counter 0, branch_cnt=0, taken_cnt=0; stall, take_branch, fwd_a, fwd_b SHALL be 0 during reset, including mid-STALL.
REQ-038 First branch after reset release SHALL be evaluated normally in IDLE.

Structure
REQ-039 Opcode constants (BEQ, BNE), fwd encodings and FSM state encoding SHALL live in shared package pipeline_pkg.
REQ-040 Per-operand match/forward logic SHALL be one sub-module branch_fwd_unit, instantiated for rs and rt.

Verification
REQ-041 BEQ rs=3 rt=4, no producers, salto=1 -> stall=0, take_branch=1 same cycle, fwd=00/00, branch_cnt=1, taken_cnt=1.
REQ-042 BNE rs=5, EX ALU writes r5 -> stall=1 one cycle, then RESOLVE with mem_rd=5: fwd_a=01, take_branch=salto.
REQ-043 BEQ rt=7, EX load to r7 -> stall=1 two cycles, then resolve with wb_rd=7: fwd_b=10.
REQ-044 BEQ rs=0 with ex_rd=0 regwrite -> no stall; flush_in=1 during STALL -> IDLE next cycle, branch_cnt unchanged.
REQ-045 Force branch_cnt to 2^CNT_W-1, resolve one branch -> wraps to 0; reset_n=0 mid-STALL -> all outputs 0, IDLE.
